// File: rtl/subtree_dispatcher_pkg.sv
// Shared types and constants for the subtree dispatcher and its per-child counters.
package subtree_dispatcher_pkg;

   localparam int NUM_CHILD_DEF = 5;
   localparam int TGT_W         = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/subtree_dispatcher_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] value
);

   logic [CNT_W-1:0] r_value;
   logic             w_at_max;

   assign w_at_max = (r_value == {CNT_W{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
      end else if (clr) begin
         r_value <= '0;
      end else if (inc && !w_at_max) begin
         r_value <= r_value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign value = r_value;

endmodule

// File: rtl/subtree_dispatcher.sv
// Routes one upstream command at a time to one of NUM_CHILD children and
// counts completed handshakes per child.
//
// state   | meaning
// ST_IDLE | nothing held, in_ready high
// ST_HOLD | command held on out_valid/out_data until the addressed child takes it
module subtree_dispatcher
   import subtree_dispatcher_pkg::*;
#(
   parameter int NUM_CHILD = NUM_CHILD_DEF,
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [TGT_W-1:0]     in_target,
   input  logic [DATA_W-1:0]    in_data,
   output logic [NUM_CHILD-1:0] out_valid,
   input  logic [NUM_CHILD-1:0] out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 err_pulse,
   output logic                 busy,
   input  logic                 cnt_clr,
   input  logic [TGT_W-1:0]     cnt_sel,
   output logic [CNT_W-1:0]     cnt_value
);

   state_e               r_state;
   logic [NUM_CHILD-1:0] r_out_valid;
   logic [DATA_W-1:0]    r_data;
   logic                 r_err;

   logic                 w_held_ready;
   logic                 w_hs;
   logic                 w_legal;
   logic                 w_accept;
   logic                 w_load;
   logic [NUM_CHILD-1:0] w_onehot;
   logic [NUM_CHILD-1:0] w_inc;
   logic [CNT_W-1:0]     w_cnt [NUM_CHILD];
   logic [CNT_W-1:0]     w_cnt_value;

   // out_valid is one-hot at the held target, so masking with it ignores the
   // ready bits of every other child.
   assign w_held_ready = |(out_ready & r_out_valid);
   assign w_hs         = (r_state == ST_HOLD) && w_held_ready;
   assign in_ready     = (r_state == ST_IDLE) || w_hs;
   assign w_legal      = 32'(in_target) < 32'(NUM_CHILD);
   assign w_accept     = in_valid && in_ready;
   assign w_load       = w_accept && w_legal;
   assign w_onehot     = NUM_CHILD'(1) << in_target;
   assign w_inc        = w_hs ? r_out_valid : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_out_valid <= '0;
         r_data      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_accept && !w_legal;
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state     <= ST_HOLD;
                  r_out_valid <= w_onehot;
                  r_data      <= in_data;
               end
            end
            ST_HOLD: begin
               // An accept in HOLD can only happen on the handshake cycle.
               if (w_load) begin
                  r_out_valid <= w_onehot;
                  r_data      <= in_data;
               end else if (w_hs) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= '0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CHILD; g++) begin : g_cnt
      sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (w_inc[g]),
         .clr   (cnt_clr),
         .value (w_cnt[g])
      );
   end

   always_comb begin
      w_cnt_value = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         if (32'(cnt_sel) == 32'(i)) begin
            w_cnt_value = w_cnt[i];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_data;
   assign err_pulse = r_err;
   assign busy      = (r_state == ST_HOLD);
   assign cnt_value = w_cnt_value;

endmodule

// File: tb/tb_subtree_dispatcher.sv
// Bench for subtree_dispatcher: directed vector table, hand sequences and random traffic vs a transaction model.
module tb_subtree_dispatcher;

   localparam int NC = 5;
   localparam int DW = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_target;
   logic [DW-1:0] in_data;
   logic [NC-1:0] out_valid;
   logic [NC-1:0] out_ready;
   logic [DW-1:0] out_data;
   logic          err_pulse;
   logic          busy;
   logic          cnt_clr;
   logic [2:0]    cnt_sel;
   logic [CW-1:0] cnt_value;

   always #10 clk = ~clk;

   subtree_dispatcher #(
      .NUM_CHILD (NC),
      .DATA_W    (DW),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_target (in_target),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_pulse (err_pulse),
      .busy      (busy),
      .cnt_clr   (cnt_clr),
      .cnt_sel   (cnt_sel),
      .cnt_value (cnt_value)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int hs_seen = 0;
   int rdy_low = 0;

   // transaction-level reference: at most one held command plus a count per child
   bit            m_held;
   int            m_tgt;
   logic [DW-1:0] m_data;
   int            m_cnt [NC];
   bit            m_err;

   typedef struct {
      bit            v;
      int            tgt;
      logic [DW-1:0] d;
      logic [NC-1:0] ordy;
      int            sel;
      bit            e_rdy;
      int            e_cnt;
      logic [NC-1:0] e_ov;
      logic [DW-1:0] e_data;
      bit            e_err;
      bit            e_busy;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_held = 1'b0;
      m_tgt  = 0;
      m_data = '0;
      m_err  = 1'b0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_target = '0;
      in_data   = '0;
      out_ready = '0;
      cnt_clr   = 1'b0;
      cnt_sel   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_err", 32'(err_pulse), 0);
      check("rst_busy", 32'(busy), 0);
      for (int s = 0; s < NC; s++) begin
         cnt_sel = 3'(s);
         #1;
         check("rst_cnt", 32'(cnt_value), 0);
      end
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      model_reset();
   endtask

   task automatic drive(input bit v, input int tgt, input logic [DW-1:0] d,
                        input logic [NC-1:0] ordy, input bit clr, input int sel);
      bit rdy, hs, acc, leg;
      int ecnt;
      in_valid  = v;
      in_target = 3'(tgt);
      in_data   = d;
      out_ready = ordy;
      cnt_clr   = clr;
      cnt_sel   = 3'(sel);
      #1;
      rdy  = !m_held || ordy[m_tgt];
      ecnt = 0;
      if (sel < NC) ecnt = m_cnt[sel];
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("cnt_value", 32'(cnt_value), 32'(ecnt));
      if (|(out_valid & ordy)) hs_seen++;
      if (!in_ready) rdy_low++;
      @(posedge clk);
      hs  = m_held && ordy[m_tgt];
      acc = v && rdy;
      leg = tgt < NC;
      if (hs) begin
         if (m_cnt[m_tgt] < (1 << CW) - 1) m_cnt[m_tgt]++;
         m_held = 1'b0;
      end
      if (clr) for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      if (acc && leg) begin
         m_held = 1'b1;
         m_tgt  = tgt;
         m_data = d;
      end
      m_err = acc && !leg;
      #1;
      check("out_valid", 32'(out_valid), m_held ? (32'd1 << m_tgt) : 32'd0);
      if (m_held) check("out_data", 32'(out_data), 32'(m_data));
      check("err_pulse", 32'(err_pulse), 32'(m_err));
      check("busy", 32'(busy), 32'(m_held));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          v  tgt data      ordy      sel  rdy cnt ov        data      err busy
      tbl[0]  = '{1, 2, 16'hA5A5, 5'b00000, 0,   1,  0, 5'b00100, 16'hA5A5, 0,  1};
      tbl[1]  = '{0, 0, 16'h0000, 5'b00000, 2,   0,  0, 5'b00100, 16'hA5A5, 0,  1};
      tbl[2]  = '{0, 0, 16'h0000, 5'b11011, 2,   0,  0, 5'b00100, 16'hA5A5, 0,  1};
      tbl[3]  = '{1, 3, 16'hBEEF, 5'b00000, 2,   0,  0, 5'b00100, 16'hA5A5, 0,  1};
      tbl[4]  = '{0, 0, 16'h0000, 5'b00100, 2,   1,  0, 5'b00000, 16'h0000, 0,  0};
      tbl[5]  = '{1, 6, 16'h1111, 5'b00000, 2,   1,  1, 5'b00000, 16'h0000, 1,  0};
      tbl[6]  = '{0, 0, 16'h0000, 5'b00000, 2,   1,  1, 5'b00000, 16'h0000, 0,  0};
      tbl[7]  = '{1, 4, 16'h1234, 5'b00000, 4,   1,  0, 5'b10000, 16'h1234, 0,  1};
      tbl[8]  = '{1, 0, 16'hFFFF, 5'b01111, 4,   0,  0, 5'b10000, 16'h1234, 0,  1};
      tbl[9]  = '{1, 0, 16'hFFFF, 5'b01111, 4,   0,  0, 5'b10000, 16'h1234, 0,  1};
      tbl[10] = '{0, 0, 16'h0000, 5'b10000, 4,   1,  0, 5'b00000, 16'h0000, 0,  0};
      tbl[11] = '{1, 7, 16'h0000, 5'b00000, 4,   1,  1, 5'b00000, 16'h0000, 1,  0};
      tbl[12] = '{0, 0, 16'h0000, 5'b00000, 7,   1,  0, 5'b00000, 16'h0000, 0,  0};

      do_reset();

      for (int k = 0; k < 13; k++) begin
         in_valid  = tbl[k].v;
         in_target = 3'(tbl[k].tgt);
         in_data   = tbl[k].d;
         out_ready = tbl[k].ordy;
         cnt_clr   = 1'b0;
         cnt_sel   = 3'(tbl[k].sel);
         #1;
         check("tbl_in_ready", 32'(in_ready), 32'(tbl[k].e_rdy));
         check("tbl_cnt", 32'(cnt_value), 32'(tbl[k].e_cnt));
         @(posedge clk);
         #1;
         check("tbl_out_valid", 32'(out_valid), 32'(tbl[k].e_ov));
         check("tbl_err", 32'(err_pulse), 32'(tbl[k].e_err));
         check("tbl_busy", 32'(busy), 32'(tbl[k].e_busy));
         if (tbl[k].e_busy) check("tbl_out_data", 32'(out_data), 32'(tbl[k].e_data));
      end

      do_reset();

      // back-to-back stream to child 0
      drive(1, 0, 16'h0100, 5'b00001, 0, 0);
      hs_seen = 0;
      rdy_low = 0;
      for (int k = 1; k < 10; k++) drive(1, 0, 16'(16'h0100 + k), 5'b00001, 0, 0);
      drive(0, 0, 16'h0000, 5'b00001, 0, 0);
      check("b2b_handshakes", 32'(hs_seen), 10);
      check("b2b_ready_low", 32'(rdy_low), 0);
      cnt_sel = 3'd0;
      #1;
      check("b2b_cnt0", 32'(cnt_value), 10);

      // saturation of child 1, then clear racing a handshake
      for (int k = 0; k < 301; k++) drive(1, 1, 16'(k), 5'b00010, 0, 1);
      drive(0, 0, 16'h0000, 5'b00010, 0, 1);
      cnt_sel = 3'd1;
      #1;
      check("sat_cnt1", 32'(cnt_value), 255);
      drive(1, 1, 16'h7777, 5'b00000, 0, 1);
      drive(0, 0, 16'h0000, 5'b00010, 1, 1);
      cnt_sel = 3'd1;
      #1;
      check("clr_cnt1", 32'(cnt_value), 0);

      for (int k = 0; k < 400; k++) begin
         bit            v;
         int            t;
         v = $urandom_range(0, 9) < 7;
         t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         drive(v, t, 16'($urandom), 5'($urandom), $urandom_range(0, 31) == 0, int'($urandom_range(0, 7)));
      end

      // reset while a command is held
      drive(1, 3, 16'hC0DE, 5'b00000, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      for (int s = 0; s < NC; s++) begin
         cnt_sel = 3'(s);
         #1;
         check("midrst_cnt", 32'(cnt_value), 0);
      end
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 1);
      model_reset();
      drive(0, 0, 16'h0000, 5'b11111, 0, 3);
      drive(1, 3, 16'h5A5A, 5'b00000, 0, 3);
      drive(0, 0, 16'h0000, 5'b01000, 0, 3);
      drive(0, 0, 16'h0000, 5'b00000, 0, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/subtree_dispatcher.md
SUBTREE_DISPATCHER -- requirements
Module: subtree_dispatcher

Interface
REQ-001 Parameter: NUM_CHILD, default 5, number of downstream child instance channels.
REQ-002 Parameter: DATA_W, default 16, payload width.
REQ-003 Parameter: CNT_W, default 8, per-child dispatch counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream command valid.
REQ-007 in_ready  output  1  dispatcher can accept a command.
REQ-008 in_target  input  3  child index, 0..NUM_CHILD-1 legal.
REQ-009 in_data  input  DATA_W  command payload.
REQ-010 out_valid  output  NUM_CHILD  one-hot valid toward the addressed child.
REQ-011 out_ready  input  NUM_CHILD  per-child ready.
REQ-012 out_data  output  DATA_W  shared payload bus to all children.
REQ-013 err_pulse  output  1  one-cycle flag for a dropped illegal-target command.
REQ-014 busy  output  1  high while a command is held for a child.
REQ-015 cnt_clr  input  1  synchronous clear of all dispatch counters.
REQ-016 cnt_sel  input  3  counter read select.
REQ-017 cnt_value  output  CNT_W  dispatch count of child cnt_sel.

Function
REQ-018 The FSM SHALL have two states: IDLE and HOLD.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in HOLD only in a cycle where out_ready[held target] is 1; otherwise 0.
REQ-020 An accept (in_valid & in_ready) with in_target < NUM_CHILD SHALL register target and data, enter HOLD, and drive out_valid one-hot at the target from the next cycle (latency 1).
REQ-021 An accept with in_target >= NUM_CHILD SHALL drop the command, assert err_pulse for exactly the next cycle, and leave the FSM state and out_valid/out_data unchanged.
REQ-022 In HOLD, out_valid and out_data SHALL stay stable until out_ready[target] is 1.
REQ-023 out_ready bits of non-addressed children SHALL be ignored.
REQ-024 On the HOLD handshake without a simultaneous legal accept, the FSM SHALL return to IDLE and out_valid SHALL be 0 next cycle.
REQ-025 On the HOLD handshake with a simultaneous legal accept, the FSM SHALL stay in HOLD and present the new command next cycle (one command per cycle sustained).
REQ-026 Each handshake SHALL increment counter[target] by 1, saturating at 2^CNT_W-1.
REQ-027 cnt_clr SHALL zero all counters next cycle and take priority over a simultaneous increment.
REQ-028 cnt_value SHALL be a combinational read of counter[cnt_sel], and 0 when cnt_sel >= NUM_CHILD.
REQ-029 busy SHALL equal (state == HOLD).

Reset
REQ-030 rst SHALL force IDLE, out_valid=0, out_data=0, err_pulse=0, and all counters=0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 rst asserted during HOLD SHALL discard the held command without a handshake or count.

Structure
REQ-033 Package subtree_dispatcher_pkg SHALL hold the state enum, the NUM_CHILD default, and TGT_W=3.
REQ-034 The per-child counter SHALL be the sub-module sat_counter (inc, clr, value; clr priority; saturating), instantiated NUM_CHILD times.

Verification
REQ-035 Accept target=2, data=0xA5A5 with out_ready=0 for 3 cycles, then out_ready[2]=1 -> out_valid=5'b00100 held 4 cycles, then counter[2]=1 and state IDLE.
REQ-036 Accept target=6 -> err_pulse=1 for one cycle, out_valid=0, and all counters unchanged.
REQ-037 10 back-to-back commands to target 0 with out_ready[0]=1 constantly -> 10 consecutive handshakes, in_ready never 0, and counter[0]=10.
REQ-038 Hold target 4 with out_ready=5'b01111 -> no handshake and out_data stable.
REQ-039 Send 300 handshakes to child 1 with CNT_W=8 -> cnt_value=255; then cnt_clr pulsed together with a handshake -> cnt_value=0.
REQ-040 Assert rst mid-HOLD -> out_valid=0 immediately, counters=0, and in_ready=1 after release.
